// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects opcode + two operands, drives the shared ALU, returns 1-2 result words with flags.
module alu_op_sequencer #(
  parameter int w       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [w-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [2:0]   alu_op,
  output logic [w-1:0] alu_a,
  output logic [w-1:0] alu_b,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [w-1:0] alu_res_lo,
  input  logic [w-1:0] alu_res_hi,
  input  logic         alu_overflow,
  input  logic         alu_cout,
  output logic [w-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [3:0]   out_flags,
  output logic         busy
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, START, WAIT, OUT0, OUT1} state_t;
  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [w-1:0]   a_q, a_d, b_q, b_d, lo_q, lo_d, hi_q, hi_d;
  logic [3:0]     flags_q, flags_d;
  logic           two_q, two_d;
  logic [TW-1:0]  wd_q, wd_d;
  logic           in_ready_q, alu_start_q, out_valid_q, out_last_q, busy_q;
  logic [2:0]     alu_op_q;
  logic [w-1:0]   alu_a_q, alu_b_q, out_q;
  logic [3:0]     out_flags_q;
  logic           xfer, oxfer;
  assign xfer  = in_valid && in_ready_q;
  assign oxfer = out_valid_q && out_ready;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    two_d   = two_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: if (xfer) begin
        op_d    = in_data[2:0];
        state_d = GET_A;
      end
      GET_A: if (xfer) begin
        a_d     = in_data;
        state_d = GET_B;
      end
      GET_B: if (xfer) begin
        b_d = in_data;
        if (op_q == 3'd7 && in_data == '0) begin
          lo_d    = '0;
          hi_d    = '0;
          flags_d = 4'b0100;
          two_d   = 1'b0;
          state_d = OUT0;
        end else state_d = START;
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + TW'(1);
        if (alu_done) begin
          lo_d    = alu_res_lo;
          hi_d    = alu_res_hi;
          flags_d = {2'b00, alu_cout, alu_overflow};
          two_d   = op_q[2] & op_q[1];
          state_d = OUT0;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          lo_d    = '0;
          hi_d    = '0;
          flags_d = 4'b1000;
          two_d   = 1'b0;
          state_d = OUT0;
        end
      end
      OUT0: if (oxfer) state_d = two_q ? OUT1 : IDLE;
      OUT1: if (oxfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      flags_q     <= '0;
      two_q       <= 1'b0;
      wd_q        <= '0;
      in_ready_q  <= 1'b0;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_flags_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      flags_q     <= flags_d;
      two_q       <= two_d;
      wd_q        <= wd_d;
      in_ready_q  <= state_d inside {IDLE, GET_A, GET_B};
      alu_start_q <= state_d == START;
      busy_q      <= state_d != IDLE;
      out_valid_q <= state_d inside {OUT0, OUT1};
      out_q       <= state_d == OUT0 ? lo_d : state_d == OUT1 ? hi_d : '0;
      out_last_q  <= state_d == OUT1 ? 1'b1 : state_d == OUT0 ? !two_d : 1'b0;
      out_flags_q <= state_d inside {OUT0, OUT1} ? flags_d : 4'b0000;
      if (state_d == START) begin
        alu_op_q <= op_d;
        alu_a_q  <= a_d;
        alu_b_q  <= b_d;
      end else if (state_d == IDLE) begin
        alu_op_q <= '0;
        alu_a_q  <= '0;
        alu_b_q  <= '0;
      end
    end
  end
  assign in_ready  = in_ready_q;
  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_flags = out_flags_q;
  assign busy      = busy_q;
endmodule
